// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Fixed-latency multiply, iterative restoring divide, MTHI/MTLO in one cycle.
module alu_muldiv #(
  parameter int WIDTH            = 32,
  parameter int MUL_LATENCY      = 3,
  parameter int DIV_BY_ZERO_ONES = 1
) (
  input  logic         clk,
  input  logic         resetn,
  alu_muldiv_if.slave  bus
);

  localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic [WIDTH-1:0]   r_a, r_b, r_div, r_rem, r_quo;
  logic               r_sgn, r_neg_q, r_neg_r, r_dbz;

  logic               w_accept, w_sgn, w_is_mul, w_is_div;
  logic               w_wr_imm, w_wr_mul, w_wr_div;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{WIDTH{sgn & v[WIDTH-1]}}, v};
  endfunction

  assign bus.req_ready = (r_state == S_IDLE) && !bus.flush;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_is_mul = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
  assign w_is_div = (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
  assign w_sgn    = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);

  // Low 2*WIDTH bits of the extended product equal the signed or unsigned product.
  assign w_prod = extend(r_a, r_sgn) * extend(r_b, r_sgn);

  // The partial remainder stays below the divisor, so a WIDTH-bit difference is exact.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;

  assign w_wr_imm = w_accept && !w_is_mul && !w_is_div;
  assign w_wr_mul = (r_state == S_MUL) && !bus.flush && (r_cnt == MUL_LAST);
  assign w_wr_div = (r_state == S_FIX) && !bus.flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL: if (bus.flush || r_cnt == MUL_LAST) w_next = S_IDLE;
      S_DIV: begin
        if (bus.flush)               w_next = S_IDLE;
        else if (r_cnt == DIV_LAST)  w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next == r_state) && (r_state == S_MUL || r_state == S_DIV))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  // Operand capture and divider iteration; purely datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= bus.req_a;
      r_b     <= bus.req_b;
      r_sgn   <= w_sgn;
      r_neg_q <= w_sgn && (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
      r_neg_r <= w_sgn && bus.req_a[WIDTH-1];
      r_dbz   <= (bus.req_b == '0);
      r_rem   <= '0;
      r_quo   <= magnitude(bus.req_a, w_sgn);
      r_div   <= magnitude(bus.req_b, w_sgn);
    end else if (r_state == S_DIV) begin
      r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wr_imm || w_wr_mul || w_wr_div;
      if (w_wr_imm) begin
        if (bus.req_op == OP_MTHI) r_hi <= bus.req_a;
        if (bus.req_op == OP_MTLO) r_lo <= bus.req_a;
      end
      if (w_wr_mul) {r_hi, r_lo} <= w_prod;
      if (w_wr_div) begin
        if (!r_dbz) begin
          r_hi <= apply_sign(r_rem, r_neg_r);
          r_lo <= apply_sign(r_quo, r_neg_q);
        end else if (DIV_BY_ZERO_ONES != 0) begin
          r_hi <= r_a;
          r_lo <= '1;
        end
      end
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per valid/ready handshake, multiplies with a fixed-latency pipeline and divides with an iterative restoring divider. The pipeline stalls on busy and picks up results on the done pulse.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be at least 4.
MUL_LATENCY, 3, cycles from accept to done for MULT/MULTU; must be at least 1.
DIV_BY_ZERO_ONES, 1, on divide by zero: 1 gives LO all-ones and HI = dividend; 0 leaves HI/LO unchanged.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (treated as no-op, done still pulses)
req_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
req_b  input  WIDTH  rt operand (divisor / multiplier)
flush  input  1  abort the in-flight operation (exception / branch squash)
busy  output  1  an operation is in flight
done  output  1  one-cycle pulse: HI/LO updated this cycle
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; hi=0, lo=0, done=0, busy=0; counters cleared. req_ready=1 from the first cycle after deassertion.
- States: IDLE, MUL, DIV, FIX.
- req_ready = (state==IDLE) && !flush. Accept = req_valid && req_ready at a rising edge. Operands and op are latched at accept; later changes on the inputs are ignored.
- MTHI/MTLO: stay in IDLE. hi (or lo) takes req_a at the edge after accept, done=1 for that one cycle, busy stays 0.
- MULT/MULTU: IDLE->MUL, busy=1. Counter runs MUL_LATENCY cycles. The full 2*WIDTH product is written as {hi,lo} at the edge ending the last cycle, done=1 in the following cycle, state->IDLE. With MUL_LATENCY=3: accept at edge 0, done high in cycle 3.
  - MULT is a signed x signed product; MULTU is unsigned x unsigned.
- DIV/DIVU: IDLE->DIV, busy=1.
  - Operands are converted to magnitudes (signed op only).
  - WIDTH iterations, one quotient bit per cycle, MSB first.
  - DIV->FIX, where quotient and remainder signs are applied and hi=remainder, lo=quotient are written.
  - FIX->IDLE with done=1. Accept at edge 0 gives done high in cycle WIDTH+1 (33 for WIDTH=32).
- Signed division rules: quotient truncates toward zero; remainder takes the sign of the dividend. Min-int / -1 gives lo=min-int, hi=0, with no trap.
- Divide by zero: detected at accept, still takes the full DIV latency. Result per DIV_BY_ZERO_ONES; done still pulses.
- Flush:
  - In MUL/DIV/FIX: state->IDLE at the next edge, hi/lo unchanged, no done pulse, busy low the following cycle.
  - In IDLE: no effect, except that it blocks acceptance that cycle.
  - Flush in the same cycle the result would be written: the write is suppressed.
- busy is 1 in MUL, DIV and FIX, else 0. done is never asserted while busy=1, except in the FIX->IDLE write cycle, where busy is already 0.
- Reset mid-operation: immediate return to the reset state; the partial result is discarded.

Test Plan:
- Reset then MTHI a=0x12345678 -> hi=0x12345678 one cycle after accept, done pulse, lo=0, busy never high.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> done in cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done in cycle 33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 with DIV_BY_ZERO_ONES=1 -> lo=0xFFFFFFFF, hi=5, done pulses.
- DIV started, flush at cycle 10 -> busy low from cycle 11, no done, hi/lo keep their prior values. A new request held during the flush cycle is accepted only the cycle after.
- resetn pulsed low mid-DIV at cycle 5 -> outputs go to reset values immediately. A later MULTU 0x10000 x 0x10000 gives hi=1, lo=0.
